// File: rtl/synth_pkg.sv
// synth_pkg: shared sizes, FSM state encoding and saturation helper for voice_mixer.
package synth_pkg;
    localparam int NUM_VOICES = 4;
    localparam int POS_W      = 12;
    localparam int KEY_W      = 8;
    localparam int SRAM_AW    = 20;
    localparam int SAMPLE_W   = 16;
    localparam int ACC_W      = 18;

    typedef enum logic [2:0] {IDLE, LATCH, READ_A, READ_B, SUM, OUT} state_e;

    localparam logic signed [ACC_W-1:0] SAT_MAX = 18'sh07FFF;
    localparam logic signed [ACC_W-1:0] SAT_MIN = 18'sh38000;

    function automatic logic signed [ACC_W-1:0] sat(input logic signed [ACC_W-1:0] a);
        return a > SAT_MAX ? SAT_MAX : a < SAT_MIN ? SAT_MIN : a;
    endfunction
endpackage

// File: rtl/voice_slot.sv
// voice_slot: one voice's key/position/active state with new-note detect and one-shot advance.
// Ports: clk_i, rst_ni (async active-low); latch_i captures key_i; advance_i steps an active
// voice after its read; key_o/pos_o/active_o expose the voice state.
module voice_slot
    import synth_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             latch_i,
    input  logic             advance_i,
    input  logic [KEY_W-1:0] key_i,
    output logic [KEY_W-1:0] key_o,
    output logic [POS_W-1:0] pos_o,
    output logic             active_o
);
    logic [KEY_W-1:0] key_q, key_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             active_q, active_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            key_q    <= '0;
            pos_q    <= '0;
            active_q <= 1'b0;
        end else begin
            key_q    <= key_d;
            pos_q    <= pos_d;
            active_q <= active_d;
        end
    end

    // The last sample ends the note without wrapping; only a key change re-arms it.
    always_comb begin
        key_d    = key_q;
        pos_d    = pos_q;
        active_d = active_q;
        if (latch_i) begin
            key_d = key_i;
            if (key_i != key_q) begin
                pos_d    = '0;
                active_d = key_i != '0;
            end
        end else if (advance_i && active_q) begin
            if (pos_q == '1) active_d = 1'b0;
            else             pos_d    = pos_q + 1'b1;
        end
    end

    assign key_o    = key_q;
    assign pos_o    = pos_q;
    assign active_o = active_q;
endmodule

// File: rtl/voice_mixer.sv
// voice_mixer: per sample tick, reads one SRAM sample for each active voice and outputs the saturated mix.
// Ports: Clk, Reset_n (async active-low); sample_tick starts a mix; keycode holds four 8-bit keys;
// sram_addr/sram_oe_n/sram_data form the SRAM read port; audio_data/audio_valid carry the mix;
// overrun is sticky and flags ticks arriving while busy.
module voice_mixer
    import synth_pkg::*;
(
    input  logic                        Clk,
    input  logic                        Reset_n,
    input  logic                        sample_tick,
    input  logic [NUM_VOICES*KEY_W-1:0] keycode,
    output logic [SRAM_AW-1:0]          sram_addr,
    output logic                        sram_oe_n,
    input  logic [SAMPLE_W-1:0]         sram_data,
    output logic [SAMPLE_W-1:0]         audio_data,
    output logic                        audio_valid,
    output logic                        overrun
);
    state_e                   state_q, state_d;
    logic [1:0]               slot_q, slot_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [SAMPLE_W-1:0]      audio_data_q, audio_data_d;
    logic                     audio_valid_q, audio_valid_d;
    logic                     overrun_q, overrun_d;

    logic [KEY_W-1:0] key    [NUM_VOICES];
    logic [POS_W-1:0] pos    [NUM_VOICES];
    logic             active [NUM_VOICES];
    logic             rd;

    for (genvar i = 0; i < NUM_VOICES; i++) begin : g_slot
        voice_slot u_slot (
            .clk_i    (Clk),
            .rst_ni   (Reset_n),
            .latch_i  (state_q == LATCH),
            .advance_i(state_q == READ_B && slot_q == 2'(i)),
            .key_i    (keycode[i*KEY_W +: KEY_W]),
            .key_o    (key[i]),
            .pos_o    (pos[i]),
            .active_o (active[i])
        );
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q       <= IDLE;
            slot_q        <= '0;
            acc_q         <= '0;
            audio_data_q  <= '0;
            audio_valid_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            slot_q        <= slot_d;
            acc_q         <= acc_d;
            audio_data_q  <= audio_data_d;
            audio_valid_q <= audio_valid_d;
            overrun_q     <= overrun_d;
        end
    end

    // SRAM port is combinational from state so reset drives it idle immediately.
    always_comb begin
        rd        = (state_q == READ_A || state_q == READ_B) && active[slot_q];
        sram_oe_n = !rd;
        sram_addr = rd ? {key[slot_q], pos[slot_q]} : '0;
    end

    always_comb begin
        state_d       = state_q;
        slot_d        = slot_q;
        acc_d         = acc_q;
        audio_data_d  = audio_data_q;
        audio_valid_d = 1'b0;
        overrun_d     = overrun_q | (sample_tick && state_q != IDLE);
        case (state_q)
            IDLE:   state_d = sample_tick ? LATCH : IDLE;
            LATCH: begin
                acc_d   = '0;
                slot_d  = '0;
                state_d = READ_A;
            end
            READ_A: state_d = READ_B;
            READ_B: begin
                if (rd) acc_d = acc_q + {{(ACC_W-SAMPLE_W){sram_data[SAMPLE_W-1]}}, sram_data};
                slot_d  = slot_q + 1'b1;
                state_d = slot_q == 2'd3 ? SUM : READ_A;
            end
            SUM: begin
                acc_d   = sat(acc_q);
                state_d = OUT;
            end
            OUT: begin
                audio_data_d  = acc_q[SAMPLE_W-1:0];
                audio_valid_d = 1'b1;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign audio_data  = audio_data_q;
    assign audio_valid = audio_valid_q;
    assign overrun     = overrun_q;
endmodule

// File: tb/tb_voice_mixer.sv
// tb_voice_mixer: randomized self-checking bench for voice_mixer against a per-note behavioural model.
module tb_voice_mixer;
    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        sample_tick = 1'b0;
    logic [31:0] keycode = '0;
    logic [19:0] sram_addr;
    logic        sram_oe_n;
    logic [15:0] sram_data;
    logic [15:0] audio_data;
    logic        audio_valid;
    logic        overrun;

    int total = 0;
    int bad = 0;

    logic        fixed_en = 1'b0;
    logic [15:0] fixed_val = '0;

    int          m_key [4];
    int          m_pos [4];
    bit          m_act [4];
    logic [15:0] m_out;
    bit          m_ovr;

    always #10 Clk = ~Clk;

    function automatic logic [15:0] mem(input logic [19:0] a);
        logic [31:0] t;
        t = {12'd0, a} * 32'h9E3779B1;
        return t[31:16];
    endfunction

    always_comb sram_data = fixed_en ? fixed_val : mem(sram_addr);

    voice_mixer dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .sample_tick(sample_tick),
        .keycode    (keycode),
        .sram_addr  (sram_addr),
        .sram_oe_n  (sram_oe_n),
        .sram_data  (sram_data),
        .audio_data (audio_data),
        .audio_valid(audio_valid),
        .overrun    (overrun)
    );

    task automatic model_reset();
        for (int s = 0; s < 4; s++) begin
            m_key[s] = 0;
            m_pos[s] = 0;
            m_act[s] = 0;
        end
        m_out = '0;
        m_ovr = 0;
    endtask

    // One sample period: the model plays each note, then the DUT is checked cycle by cycle.
    task automatic run_tick(input int extra_at, input int rst_at);
        int          addr_e [4];
        bit          rd_e [4];
        int          sum;
        int          kc;
        logic [15:0] v;
        logic [15:0] exp;
        logic        oe_e;
        logic [19:0] a_e;
        sum = 0;
        for (int s = 0; s < 4; s++) begin
            kc = int'(keycode[8*s +: 8]);
            if (kc != m_key[s]) begin
                m_pos[s] = 0;
                m_act[s] = kc != 0;
            end
            m_key[s] = kc;
            rd_e[s] = m_act[s];
            addr_e[s] = m_act[s] ? m_key[s] * 4096 + m_pos[s] : 0;
            if (m_act[s]) begin
                v = fixed_en ? fixed_val : mem(20'(addr_e[s]));
                sum += int'($signed(v));
                if (m_pos[s] == 4095) m_act[s] = 0;
                else m_pos[s]++;
            end
        end
        if (sum > 32767) sum = 32767;
        if (sum < -32768) sum = -32768;
        exp = 16'(sum);
        @(negedge Clk);
        sample_tick = 1'b1;
        for (int j = 0; j <= 12; j++) begin
            @(negedge Clk);
            sample_tick = 1'b0;
            oe_e = 1'b1;
            a_e = '0;
            if (j >= 1 && j <= 8) begin
                oe_e = !rd_e[(j-1)/2];
                a_e = 20'(addr_e[(j-1)/2]);
            end
            total++;
            if (sram_oe_n !== oe_e) begin
                bad++;
                $display("FAIL oe_n j=%0d got=%b want=%b", j, sram_oe_n, oe_e);
            end
            total++;
            if (sram_addr !== a_e) begin
                bad++;
                $display("FAIL sram_addr j=%0d got=%h want=%h", j, sram_addr, a_e);
            end
            total++;
            if (audio_valid !== (j == 11)) begin
                bad++;
                $display("FAIL audio_valid j=%0d got=%b want=%b", j, audio_valid, j == 11);
            end
            total++;
            if (audio_data !== (j >= 11 ? exp : m_out)) begin
                bad++;
                $display("FAIL audio_data j=%0d got=%h want=%h", j, audio_data, j >= 11 ? exp : m_out);
            end
            if (j == 12) begin
                total++;
                if (overrun !== m_ovr) begin
                    bad++;
                    $display("FAIL overrun got=%b want=%b", overrun, m_ovr);
                end
            end
            if (j == rst_at) begin
                Reset_n = 1'b0;
                #1;
                model_reset();
                total++;
                if ({audio_data, audio_valid, overrun, sram_oe_n, sram_addr} !== {16'h0, 1'b0, 1'b0, 1'b1, 20'h0}) begin
                    bad++;
                    $display("FAIL mid_reset got=%h/%b/%b/%b/%h want=0000/0/0/1/00000",
                             audio_data, audio_valid, overrun, sram_oe_n, sram_addr);
                end
                @(negedge Clk);
                Reset_n = 1'b1;
                return;
            end
            if (j == extra_at) begin
                sample_tick = 1'b1;
                m_ovr = 1;
            end
        end
        m_out = exp;
        if (extra_at >= 0) begin
            for (int j = 0; j < 14; j++) begin
                @(negedge Clk);
                total++;
                if (audio_valid !== 1'b0 || audio_data !== m_out) begin
                    bad++;
                    $display("FAIL extra_output j=%0d valid=%b data=%h want 0/%h", j, audio_valid, audio_data, m_out);
                end
            end
        end
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        model_reset();
        repeat (2) @(negedge Clk);
        total++;
        if ({audio_data, audio_valid, overrun, sram_oe_n, sram_addr} !== {16'h0, 1'b0, 1'b0, 1'b1, 20'h0}) begin
            bad++;
            $display("FAIL reset got=%h/%b/%b/%b/%h want=0000/0/0/1/00000",
                     audio_data, audio_valid, overrun, sram_oe_n, sram_addr);
        end
        Reset_n = 1'b1;
        @(negedge Clk);
    endtask

    task automatic test_silence();
        keycode = '0;
        run_tick(-1, -1);
    endtask

    task automatic test_single();
        fixed_en = 1'b1;
        fixed_val = 16'h0032;
        keycode = 32'h0000_0014;
        run_tick(-1, -1);
        run_tick(-1, -1);
        fixed_en = 1'b0;
    endtask

    task automatic test_saturate();
        fixed_en = 1'b1;
        fixed_val = 16'h7000;
        keycode = 32'h0007_0003;
        run_tick(-1, -1);
        fixed_val = 16'h9000;
        run_tick(-1, -1);
        keycode = 32'h0505_0505;
        fixed_val = 16'h8000;
        run_tick(-1, -1);
        fixed_en = 1'b0;
    endtask

    task automatic test_random();
        logic [7:0] pick [4];
        pick[0] = 8'd5;
        pick[1] = 8'd9;
        pick[2] = 8'd20;
        pick[3] = 8'd200;
        for (int t = 0; t < 24; t++) begin
            for (int s = 0; s < 4; s++) begin
                case ($urandom_range(0, 2))
                    0: keycode[8*s +: 8] = 8'd0;
                    1: keycode[8*s +: 8] = pick[$urandom_range(0, 3)];
                    default: ;
                endcase
            end
            run_tick(-1, -1);
        end
    endtask

    task automatic test_overrun();
        keycode = 32'h0009_0014;
        run_tick(3, -1);
        run_tick(-1, -1);
    endtask

    task automatic test_one_shot();
        test_reset();
        keycode = 32'h0000_0014;
        for (int t = 0; t < 4097; t++) run_tick(-1, -1);
        keycode = '0;
        run_tick(-1, -1);
        keycode = 32'h0000_0014;
        run_tick(-1, -1);
        run_tick(-1, -1);
    endtask

    task automatic test_reset_mid();
        keycode = 32'h0021_0000;
        run_tick(-1, -1);
        run_tick(-1, -1);
        run_tick(-1, 6);
        run_tick(-1, -1);
        run_tick(-1, -1);
    endtask

    initial begin
        test_reset();
        test_silence();
        test_single();
        test_saturate();
        test_random();
        test_overrun();
        test_reset_mid();
        test_one_shot();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/voice_mixer.md
VOICE_MIXER -- requirements
Module: voice_mixer

Interface
REQ-001 SHALL have port: Clk  in  1  system clock, 50 MHz, all logic rising-edge.
REQ-002 SHALL have port: Reset_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: sample_tick  in  1  one-Clk pulse per audio sample, already synchronous to Clk.
REQ-004 SHALL have port: keycode  in  32  four 8-bit key slots; slot i = keycode[8i+7:8i]; 0 = no key.
REQ-005 SHALL have port: sram_addr  out  20  SRAM read address.
REQ-006 SHALL have port: sram_oe_n  out  1  SRAM output enable, active-low.
REQ-007 SHALL have port: sram_data  in  16  signed two's-complement sample returned by SRAM.
REQ-008 SHALL have port: audio_data  out  16  mixed signed sample; feeds the codec driver DATA input.
REQ-009 SHALL have port: audio_valid  out  1  one-Clk pulse when audio_data updates.
REQ-010 SHALL have port: overrun  out  1  sticky; set when a sample_tick arrives while the mixer is busy.

Function
REQ-011 SHALL implement FSM states IDLE, LATCH, READ_A, READ_B, SUM, OUT.
REQ-012 SHALL transition IDLE->LATCH on sample_tick; all other states SHALL ignore sample_tick except to set overrun.
REQ-013 LATCH SHALL capture keycode into the per-slot key registers; a slot whose key differs from its previous key SHALL reset its position to 0 and set active = (key != 0).
REQ-014 SHALL visit slots 0..3 in order, two cycles each (READ_A, READ_B), regardless of activity; slot index wraps 3->SUM.
REQ-015 For an active slot: sram_addr = {key, pos[11:0]} in both cycles; sram_oe_n = 0 in both; sram_data sampled at end of READ_B.
REQ-016 For an inactive slot: sram_oe_n = 1, sram_addr = 0, contribution = 0.
REQ-017 After an active slot's read, pos SHALL increment; a read at pos = 4095 SHALL clear active (one-shot) with no wrap; the voice stays silent until its key changes.
REQ-018 Identical keys in two slots SHALL play as independent voices.
REQ-019 Accumulator: 18-bit signed; each sample sign-extended and added; cleared in LATCH.
REQ-020 SUM SHALL saturate the accumulator to [-32768, 32767].
REQ-021 OUT SHALL load audio_data, assert audio_valid for exactly one cycle, and return to IDLE.
REQ-022 Latency SHALL be fixed: tick sampled at edge k gives audio_valid high in cycle k+11. Total busy time is 11 cycles.
REQ-023 audio_data SHALL hold its value between audio_valid pulses.
REQ-024 Outside active READ cycles, sram_oe_n = 1 and sram_addr = 0.

Reset
REQ-025 Reset_n low SHALL force IDLE at once, mid-operation included.
REQ-026 Reset_n low SHALL clear: audio_data = 0, audio_valid = 0, overrun = 0, sram_oe_n = 1, sram_addr = 0, all keys = 0, all pos = 0, all active = 0, accumulator = 0.
REQ-027 After reset release, the first tick SHALL treat every non-zero key as a new note.

Structure
REQ-028 Package synth_pkg SHALL hold NUM_VOICES = 4, POS_W = 12, KEY_W = 8, SRAM_AW = 20, SAMPLE_W = 16 and the FSM state enum.
REQ-029 A sub-module voice_slot (key, pos, active registers; new-note detect; advance/finish logic) SHALL be instantiated NUM_VOICES times.

Verification
REQ-030 Reset, keycode = 0, one tick -> no sram_oe_n assertion; audio_data = 0; audio_valid at k+11.
REQ-031 keycode = {0,0,0,8'd20}, sram_data = 16'h0032 -> sram_addr = 20'h14000 on first tick, 20'h14001 on second; audio_data = 16'h0032.
REQ-032 Slots 16'h7000 and 16'h7000 (two active) -> audio_data = 16'h7FFF; two slots of 16'h9000 -> 16'h8000.
REQ-033 Hold a key for 4097 ticks -> the 4096th read uses pos 4095; the 4097th tick does no read; key 0 then the key again restarts at pos 0.
REQ-034 A second tick 3 cycles after the first -> overrun = 1; no extra output; audio_valid still at k+11 only.
REQ-035 Reset_n low during READ_B of slot 2 -> outputs at reset values at once; the next tick after release restarts at pos 0.
